// File: rtl/wash_sequencer.sv
// Washing-machine cycle sequencer: drives per-phase timers through FILL/WASH/DRAIN/RINSE/SPIN,
// with pause, door interlock and a per-phase watchdog.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for a start edge with the door closed
// FILL  | filling drum (first pass leads to WASH, later to RINSE)
// WASH  | main wash
// DRAIN | draining; loops back to FILL while rinses remain
// RINSE | one rinse pass
// SPIN  | final spin
// DONE  | cycle complete, start edge returns to IDLE
// FAULT | door opened or watchdog expired; held until reset
module wash_sequencer #(
   parameter int unsigned NUM_RINSE      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       pause,
   input  logic       door_open,
   input  logic [4:0] phase_done,
   output logic [4:0] timer_start,
   output logic       timer_clear,
   output logic       timer_pause,
   output logic [2:0] state,
   output logic [3:0] rinse_left,
   output logic       door_lock,
   output logic       cycle_done,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_DRAIN = 3'd3,
      S_RINSE = 3'd4,
      S_SPIN  = 3'd5,
      S_DONE  = 3'd6,
      S_FAULT = 3'd7
   } state_t;

   state_t      st_q, st_n;
   logic        start_q;
   logic        wash_complete_q, wash_complete_n;
   logic [3:0]  rl_q, rl_n;
   logic [31:0] wd_q, wd_n;
   logic        start_edge;
   logic        own_done;
   logic        timeout_hit;
   logic [4:0]  ts_q;
   logic        tc_q, tp_q, dl_q, cd_q, flt_q;

   function automatic logic is_phase(input state_t s);
      return (s >= S_FILL) && (s <= S_SPIN);
   endfunction

   function automatic logic [4:0] phase_mask(input state_t s);
      logic [4:0] m;
      m = 5'b00000;
      case (s)
         S_FILL:  m = 5'b00001;
         S_WASH:  m = 5'b00010;
         S_DRAIN: m = 5'b00100;
         S_RINSE: m = 5'b01000;
         S_SPIN:  m = 5'b10000;
         default: m = 5'b00000;
      endcase
      return m;
   endfunction

   assign start_edge  = start & ~start_q;
   assign own_done    = |(phase_done & phase_mask(st_q));
   // 33-bit compare so a watchdog at full scale cannot wrap past the limit
   assign timeout_hit = ({1'b0, wd_q} + 33'd1) >= {1'b0, TIMEOUT_CYCLES};

   always_comb begin
      st_n            = st_q;
      wash_complete_n = wash_complete_q;
      rl_n            = rl_q;
      wd_n            = wd_q;
      case (st_q)
         S_IDLE: begin
            wash_complete_n = 1'b0;
            if (start_edge && !door_open) begin
               st_n = S_FILL;
               rl_n = 4'(NUM_RINSE);
            end
         end
         S_DONE: begin
            if (start_edge) st_n = S_IDLE;
         end
         S_FAULT: begin
            st_n = S_FAULT;
         end
         default: begin
            if (door_open) begin
               st_n = S_FAULT;
            end else if (pause) begin
               st_n = st_q;
            end else if (own_done) begin
               case (st_q)
                  S_FILL:  st_n = wash_complete_q ? S_RINSE : S_WASH;
                  S_WASH: begin
                     st_n            = S_DRAIN;
                     wash_complete_n = 1'b1;
                  end
                  S_DRAIN: st_n = (rl_q != 4'd0) ? S_FILL : S_SPIN;
                  S_RINSE: begin
                     st_n = S_DRAIN;
                     rl_n = rl_q - 4'd1;
                  end
                  S_SPIN:  st_n = S_DONE;
                  default: st_n = st_q;
               endcase
            end else if (timeout_hit) begin
               st_n = S_FAULT;
            end else begin
               wd_n = wd_q + 32'd1;
            end
         end
      endcase
      if (st_n != st_q) wd_n = 32'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q            <= S_IDLE;
         start_q         <= 1'b0;
         wash_complete_q <= 1'b0;
         rl_q            <= 4'd0;
         wd_q            <= 32'd0;
         ts_q            <= 5'd0;
         tc_q            <= 1'b0;
         tp_q            <= 1'b0;
         dl_q            <= 1'b0;
         cd_q            <= 1'b0;
         flt_q           <= 1'b0;
      end else begin
         st_q            <= st_n;
         start_q         <= start;
         wash_complete_q <= wash_complete_n;
         rl_q            <= rl_n;
         wd_q            <= wd_n;
         ts_q            <= (st_n != st_q) ? phase_mask(st_n) : 5'd0;
         tc_q            <= (st_n != st_q) && is_phase(st_n);
         tp_q            <= is_phase(st_n) && pause;
         dl_q            <= is_phase(st_n);
         cd_q            <= (st_n == S_DONE);
         flt_q           <= (st_n == S_FAULT);
      end
   end

   assign state       = st_q;
   assign rinse_left  = rl_q;
   assign timer_start = ts_q;
   assign timer_clear = tc_q;
   assign timer_pause = tp_q;
   assign door_lock   = dl_q;
   assign cycle_done  = cd_q;
   assign fault       = flt_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: fixed vector table, directed corner sequences and random
// stimulus checked against a phase-list reference model.
module tb_wash_sequencer;
   localparam int NR   = 1;
   localparam int TO   = 100;
   localparam int NSEQ = 4 + 3 * NR;

   logic       clk = 1'b0;
   logic       reset, start, pause, door_open;
   logic [4:0] phase_done;
   logic [4:0] timer_start;
   logic       timer_clear, timer_pause, door_lock, cycle_done, fault;
   logic [2:0] state;
   logic [3:0] rinse_left;

   int checks   = 0;
   int failures = 0;

   wash_sequencer #(.NUM_RINSE(NR), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .pause(pause), .door_open(door_open),
      .phase_done(phase_done), .timer_start(timer_start), .timer_clear(timer_clear),
      .timer_pause(timer_pause), .state(state), .rinse_left(rinse_left),
      .door_lock(door_lock), .cycle_done(cycle_done), .fault(fault)
   );

   always #5 clk = ~clk;

   // Reference model: cycle is an ordered list of phase codes walked by an index.
   int seq[NSEQ];
   int m_mode;   // 0 idle, 1 running, 2 done, 3 fault
   int m_idx, m_wd, m_rl;
   bit m_prev, m_first, m_tp;

   function automatic int rinses_before(input int idx);
      int n = 0;
      for (int k = 0; k < idx; k++) if (seq[k] == 4) n++;
      return n;
   endfunction

   function automatic void model_step(input logic r, s, p, d, input logic [4:0] pd);
      bit edge_s;
      if (r) begin
         m_mode = 0; m_idx = 0; m_wd = 0; m_rl = 0; m_prev = 0; m_first = 0; m_tp = 0;
         return;
      end
      edge_s  = s && !m_prev;
      m_prev  = s;
      m_first = 0;
      case (m_mode)
         0: if (edge_s && !d) begin
            m_mode = 1; m_idx = 0; m_wd = 0; m_first = 1; m_rl = NR;
         end
         1: begin
            if (d) m_mode = 3;
            else if (p) begin end
            else if (pd[seq[m_idx] - 1]) begin
               if (m_idx == NSEQ - 1) m_mode = 2;
               else begin
                  m_idx++; m_first = 1; m_wd = 0;
                  m_rl = NR - rinses_before(m_idx);
               end
            end else if (m_wd + 1 >= TO) m_mode = 3;
            else m_wd++;
         end
         2: if (edge_s) m_mode = 0;
         default: begin end
      endcase
      m_tp = (m_mode == 1) && p;
   endfunction

   function automatic int exp_state();
      case (m_mode)
         0: return 0;
         1: return seq[m_idx];
         2: return 6;
         default: return 7;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic drive_edge(input logic r, s, p, d, input logic [4:0] pd);
      reset = r; start = s; pause = p; door_open = d; phase_done = pd;
      @(posedge clk);
      model_step(r, s, p, d, pd);
      #1;
   endtask

   task automatic compare_model();
      logic [4:0] ets;
      ets = (m_mode == 1 && m_first) ? 5'(1 << (seq[m_idx] - 1)) : 5'd0;
      chk("state", 32'(state), 32'(exp_state()));
      chk("timer_start", 32'(timer_start), 32'(ets));
      chk("timer_clear", 32'(timer_clear), 32'(m_mode == 1 && m_first));
      chk("timer_pause", 32'(timer_pause), 32'(m_tp));
      chk("rinse_left", 32'(rinse_left), 32'(m_rl));
      chk("door_lock", 32'(door_lock), 32'(m_mode == 1));
      chk("cycle_done", 32'(cycle_done), 32'(m_mode == 2));
      chk("fault", 32'(fault), 32'(m_mode == 3));
   endtask

   task automatic step(input logic r, s, p, d, input logic [4:0] pd);
      drive_edge(r, s, p, d, pd);
      compare_model();
   endtask

   // Wait 4 idle cycles in the current phase, then pulse its done bit.
   task automatic finish_phase(input int code);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 5'd0);
      step(0, 0, 0, 0, 5'(1 << (code - 1)));
   endtask

   typedef struct {
      logic       r, s, p, d;
      logic [4:0] pd;
      logic [2:0] e_st;
      logic [4:0] e_ts;
      logic       e_tc, e_dl, e_cd, e_flt;
      logic [3:0] e_rl;
   } vec_t;

   function automatic vec_t mk(input logic r, s, p, d, input logic [4:0] pd,
                               input logic [2:0] st, input logic [4:0] ts, input logic tc,
                               input logic [3:0] rl, input logic dl, cd, flt);
      vec_t v;
      v.r = r; v.s = s; v.p = p; v.d = d; v.pd = pd;
      v.e_st = st; v.e_ts = ts; v.e_tc = tc; v.e_rl = rl; v.e_dl = dl; v.e_cd = cd; v.e_flt = flt;
      return v;
   endfunction

   vec_t tbl[19];

   initial begin
      int k, ts_pulses;
      logic [2:0] prev_st;
      int exp_codes[7] = '{1, 2, 3, 1, 4, 3, 5};
      k = 0;
      seq[k++] = 1; seq[k++] = 2; seq[k++] = 3;
      for (int r = 0; r < NR; r++) begin seq[k++] = 1; seq[k++] = 4; seq[k++] = 3; end
      seq[k++] = 5;
      reset = 1; start = 0; pause = 0; door_open = 0; phase_done = 0;
      model_step(1, 0, 0, 0, 5'd0);

      //            r s p d  pd        st  ts        tc rl  dl cd flt
      tbl[0]  = mk(1,0,0,0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0,1,0,1, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0);
      tbl[2]  = mk(0,0,0,0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0);
      tbl[3]  = mk(0,1,0,0, 5'b00000, 1, 5'b00001, 1, 1, 1, 0, 0);
      tbl[4]  = mk(0,0,0,0, 5'b00000, 1, 5'b00000, 0, 1, 1, 0, 0);
      tbl[5]  = mk(0,0,0,0, 5'b00001, 2, 5'b00010, 1, 1, 1, 0, 0);
      tbl[6]  = mk(0,0,0,0, 5'b11101, 2, 5'b00000, 0, 1, 1, 0, 0);
      tbl[7]  = mk(0,0,0,0, 5'b00010, 3, 5'b00100, 1, 1, 1, 0, 0);
      tbl[8]  = mk(0,0,0,0, 5'b00100, 1, 5'b00001, 1, 1, 1, 0, 0);
      tbl[9]  = mk(0,0,0,0, 5'b00001, 4, 5'b01000, 1, 1, 1, 0, 0);
      tbl[10] = mk(0,0,0,0, 5'b01000, 3, 5'b00100, 1, 0, 1, 0, 0);
      tbl[11] = mk(0,0,0,0, 5'b00100, 5, 5'b10000, 1, 0, 1, 0, 0);
      tbl[12] = mk(0,0,0,0, 5'b10000, 6, 5'b00000, 0, 0, 0, 1, 0);
      tbl[13] = mk(0,1,0,0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0);
      tbl[14] = mk(0,1,0,0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0);
      tbl[15] = mk(0,0,0,0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0);
      tbl[16] = mk(0,1,0,0, 5'b00000, 1, 5'b00001, 1, 1, 1, 0, 0);
      tbl[17] = mk(0,0,0,1, 5'b00000, 7, 5'b00000, 0, 1, 0, 0, 1);
      tbl[18] = mk(1,0,0,0, 5'b00000, 0, 5'b00000, 0, 0, 0, 0, 0);

      for (int i = 0; i < 19; i++) begin
         drive_edge(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].d, tbl[i].pd);
         chk($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].e_st));
         chk($sformatf("tbl%0d.timer_start", i), 32'(timer_start), 32'(tbl[i].e_ts));
         chk($sformatf("tbl%0d.timer_clear", i), 32'(timer_clear), 32'(tbl[i].e_tc));
         chk($sformatf("tbl%0d.rinse_left", i), 32'(rinse_left), 32'(tbl[i].e_rl));
         chk($sformatf("tbl%0d.door_lock", i), 32'(door_lock), 32'(tbl[i].e_dl));
         chk($sformatf("tbl%0d.cycle_done", i), 32'(cycle_done), 32'(tbl[i].e_cd));
         chk($sformatf("tbl%0d.fault", i), 32'(fault), 32'(tbl[i].e_flt));
      end

      // Full cycle, each phase completing 5 cycles after entry.
      step(1, 0, 0, 0, 5'd0);
      step(0, 0, 0, 0, 5'd0);
      ts_pulses = 0;
      step(0, 1, 0, 0, 5'd0);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("full.entry%0d", i), 32'(state), 32'(exp_codes[i]));
         if (timer_start != 0) ts_pulses++;
         prev_st = state;
         for (int j = 0; j < 4; j++) begin
            step(0, 0, 0, 0, 5'd0);
            if (timer_start != 0) ts_pulses++;
         end
         step(0, 0, 0, 0, 5'(1 << (exp_codes[i] - 1)));
         if (prev_st == 3'd4) chk("full.rinse_dec", 32'(rinse_left), 32'd0);
      end
      chk("full.done_state", 32'(state), 32'd6);
      chk("full.cycle_done", 32'(cycle_done), 32'd1);
      chk("full.ts_pulses", 32'(ts_pulses), 32'd7);

      // Pause in WASH with its done bit already high.
      step(1, 0, 0, 0, 5'd0);
      step(0, 1, 0, 0, 5'd0);
      step(0, 0, 0, 0, 5'b00001);
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 1, 0, 5'b00010);
         if (state != 3'd2 || timer_pause != 1'b1) chk("pause.hold", {29'd0, state}, 32'd2);
      end
      chk("pause.tp", 32'(timer_pause), 32'd1);
      step(0, 0, 0, 0, 5'b00010);
      chk("pause.release", 32'(state), 32'd3);

      // Watchdog expiry in FILL.
      step(1, 0, 0, 0, 5'd0);
      step(0, 1, 0, 0, 5'd0);
      for (int i = 0; i < 99; i++) step(0, 0, 0, 0, 5'd0);
      chk("wd.before", 32'(state), 32'd1);
      step(0, 0, 0, 0, 5'd0);
      chk("wd.state", 32'(state), 32'd7);
      chk("wd.fault", 32'(fault), 32'd1);
      chk("wd.door_lock", 32'(door_lock), 32'd0);
      step(0, 0, 0, 0, 5'd0);
      step(0, 1, 0, 0, 5'd0);
      chk("wd.start_ignored", 32'(state), 32'd7);

      // Door: ignored start when open; door beats phase_done in SPIN.
      step(1, 0, 0, 0, 5'd0);
      step(0, 1, 0, 1, 5'd0);
      chk("door.idle", 32'(state), 32'd0);
      step(0, 0, 0, 0, 5'd0);
      step(0, 1, 0, 0, 5'd0);
      for (int i = 0; i < 6; i++) finish_phase(exp_codes[i]);
      chk("door.in_spin", 32'(state), 32'd5);
      step(0, 0, 0, 1, 5'b10000);
      chk("door.fault", 32'(state), 32'd7);

      // Reset mid-RINSE, then a fresh cycle goes FILL->WASH.
      step(1, 0, 0, 0, 5'd0);
      step(0, 1, 0, 0, 5'd0);
      for (int i = 0; i < 4; i++) finish_phase(exp_codes[i]);
      chk("rst.in_rinse", 32'(state), 32'd4);
      step(1, 0, 0, 0, 5'd0);
      chk("rst.state", 32'(state), 32'd0);
      chk("rst.clear", 32'(timer_clear), 32'd0);
      step(0, 1, 0, 0, 5'd0);
      chk("rst.fill", 32'(state), 32'd1);
      step(0, 0, 0, 0, 5'b00001);
      chk("rst.wash", 32'(state), 32'd2);

      // Random stimulus against the model.
      for (int i = 0; i < 5000; i++) begin
         step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 119) == 0,
              ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 SHALL have parameter NUM_RINSE, default 2, rinse passes per cycle; legal range 1..15.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 500000000, maximum clocks spent in one phase before a fault (32-bit).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  user start button (level, edge-detected internally).
REQ-006 SHALL have port pause  input  1  user pause switch (level).
REQ-007 SHALL have port door_open  input  1  door sensor, 1 = open.
REQ-008 SHALL have port phase_done  input  5  per-phase timer done flags, bit0 FILL, 1 WASH, 2 DRAIN, 3 RINSE, 4 SPIN.
REQ-009 SHALL have port timer_start  output  5  one-hot phase timer start pulse, same bit order as phase_done.
REQ-010 SHALL have port timer_clear  output  1  clear pulse to all phase timers.
REQ-011 SHALL have port timer_pause  output  1  pause level to all phase timers.
REQ-012 SHALL have port state  output  3  current state code.
REQ-013 SHALL have port rinse_left  output  4  rinse passes still to run.
REQ-014 SHALL have port door_lock  output  1  door latch command.
REQ-015 SHALL have port cycle_done  output  1  cycle complete indicator.
REQ-016 SHALL have port fault  output  1  fault indicator.

Function
REQ-017 SHALL encode state as IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6, FAULT=7, with all outputs registered.
REQ-018 SHALL detect a start edge as start=1 in this cycle and start=0 in the previous cycle, using one internal register.
REQ-019 SHALL move IDLE->FILL on a start edge with door_open=0, load rinse_left=NUM_RINSE, and ignore the start edge when door_open=1.
REQ-020 SHALL use the sequence FILL->WASH->DRAIN, then while rinse_left>0 run FILL->RINSE->DRAIN, decrementing rinse_left on leaving RINSE; DRAIN with rinse_left=0 goes to SPIN, then SPIN->DONE.
REQ-021 SHALL select the second FILL's successor as RINSE (not WASH) using an internal wash_complete flag, set on leaving WASH and cleared in IDLE.
REQ-022 SHALL leave a phase state one cycle after it samples its own phase_done bit high with timer_pause=0; other phase_done bits are ignored.
REQ-023 SHALL assert timer_clear and the matching timer_start bit for exactly the first cycle of each phase state; both are 0 in all other cycles.
REQ-024 SHALL drive timer_pause=pause in phase states; in that case the state is held, phase_done is ignored and the watchdog is frozen. timer_pause=0 elsewhere.
REQ-025 SHALL run a 32-bit watchdog: cleared on phase entry, +1 per unpaused phase cycle, FAULT when it reaches TIMEOUT_CYCLES.
REQ-026 SHALL enter FAULT from any phase state when door_open=1.
REQ-027 SHALL assert door_lock=1 in states FILL..SPIN and 0 otherwise.
REQ-028 SHALL assert cycle_done=1 only in DONE and fault=1 only in FAULT.
REQ-029 SHALL move DONE->IDLE on a start edge, without starting a new cycle in that same edge.
REQ-030 SHALL hold FAULT until reset; start is ignored in FAULT.
REQ-031 SHALL apply this priority in one cycle: reset > door_open fault > pause > phase_done > watchdog timeout.
REQ-032 SHALL ignore start edges in FILL..SPIN.

Reset
REQ-033 SHALL, with reset=1 at a clock edge, go to IDLE with timer_start=0, timer_clear=0, timer_pause=0, rinse_left=0, door_lock=0, cycle_done=0, fault=0, watchdog=0, wash_complete=0, start edge register=0.
REQ-034 SHALL apply reset mid-cycle from any state, including PAUSED and FAULT, with no extra timer_clear pulse.

Verification (NUM_RINSE=1, TIMEOUT_CYCLES=100)
REQ-035 SHALL cover a full cycle: start edge, then pulse each expected phase_done 5 cycles after entry -> states 1,2,3,1,4,3,5,6; one timer_start pulse per phase; rinse_left 1->0 on leaving RINSE; cycle_done=1.
REQ-036 SHALL cover pause: pause=1 for 20 cycles in WASH with phase_done=1 -> state stays 2 and timer_pause=1; on release, WASH->DRAIN one cycle later.
REQ-037 SHALL cover watchdog: FILL with no phase_done for 100 cycles -> state=7, fault=1, door_lock=0; a later start edge changes nothing.
REQ-038 SHALL cover the door: start edge with door_open=1 -> stays IDLE; door_open=1 in SPIN together with phase_done[4] -> FAULT (not DONE).
REQ-039 SHALL cover reset mid-RINSE: all outputs at reset values next cycle, then a new start edge -> FILL followed by WASH (not RINSE).
